// File: rtl/fifo_mult_consumer_if.sv
// Operand-FIFO pop handshake and product valid/ready bus of the FIFO multiplier consumer.
// master: consumer (DUT) side; slave: FIFO/sink side.
interface fifo_mult_consumer_if;
    logic [2:0]  left_sig;
    logic        read_req;
    logic [15:0] fifo_read_data;
    logic [15:0] product;
    logic        product_valid;
    logic        product_ready;
    logic        busy;
    logic [7:0]  prod_count;

    modport master (
        input  left_sig, fifo_read_data, product_ready,
        output read_req, product, product_valid, busy, prod_count
    );

    modport slave (
        output left_sig, fifo_read_data, product_ready,
        input  read_req, product, product_valid, busy, prod_count
    );
endinterface

// File: rtl/fifo_mult_consumer.sv
// Pops {a,b} words from the operand FIFO and multiplies them with an 8-cycle shift-add loop.
// Optional macro SIGNED_MULT_EN: two's-complement operands (sign-magnitude around the same loop).
module fifo_mult_consumer #(
    parameter logic [2:0] FIFO_DEEP = 3'd4,
    parameter int         OPERAND_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    fifo_mult_consumer_if.master bus
);
    localparam int PROD_W = 2 * OPERAND_W;
    localparam int ITER_W = $clog2(OPERAND_W);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(OPERAND_W - 1);
    localparam logic [PROD_W-1:0] ONE_PROD  = PROD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_MUL,
        S_DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [OPERAND_W-1:0] op_a;
    logic [OPERAND_W-1:0] op_b;
    logic [PROD_W-1:0]    acc;
    logic [PROD_W-1:0]    partial;
    logic [PROD_W-1:0]    acc_next;
    logic [PROD_W-1:0]    result;
    logic [ITER_W-1:0]    iter;

`ifdef SIGNED_MULT_EN
    localparam logic [OPERAND_W-1:0] ONE_OP = OPERAND_W'(1);
    logic neg;

    // |v| fits in OPERAND_W unsigned bits, including the most negative value.
    function automatic logic [OPERAND_W-1:0] magnitude(input logic signed [OPERAND_W-1:0] v);
        logic [OPERAND_W-1:0] u;
        u = v;
        return u[OPERAND_W-1] ? (~u + ONE_OP) : u;
    endfunction

    function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] mag,
                                                      input logic           is_neg);
        return is_neg ? (~mag + ONE_PROD) : mag;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (bus.left_sig != FIFO_DEEP) next_state = S_RD;
            S_RD:   next_state = S_WAIT;
            S_WAIT: next_state = S_MUL;
            S_MUL:  if (iter == ITER_LAST) next_state = S_DONE;
            S_DONE: if (bus.product_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        partial  = op_b[iter] ? ({{OPERAND_W{1'b0}}, op_a} << iter) : '0;
        acc_next = acc + partial;
`ifdef SIGNED_MULT_EN
        result   = apply_sign(acc_next, neg);
`else
        result   = acc_next;
`endif
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.read_req      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.product       <= '0;
            bus.product_valid <= 1'b0;
            bus.prod_count    <= '0;
            op_a              <= '0;
            op_b              <= '0;
            acc               <= '0;
            iter              <= '0;
`ifdef SIGNED_MULT_EN
            neg               <= 1'b0;
`endif
        end else begin
            bus.read_req <= (next_state == S_RD);
            bus.busy     <= (next_state != S_IDLE);
            case (state)
                S_WAIT: begin
`ifdef SIGNED_MULT_EN
                    op_a <= magnitude(bus.fifo_read_data[PROD_W-1:OPERAND_W]);
                    op_b <= magnitude(bus.fifo_read_data[OPERAND_W-1:0]);
                    neg  <= bus.fifo_read_data[PROD_W-1] ^ bus.fifo_read_data[OPERAND_W-1];
`else
                    op_a <= bus.fifo_read_data[PROD_W-1:OPERAND_W];
                    op_b <= bus.fifo_read_data[OPERAND_W-1:0];
`endif
                    acc  <= '0;
                    iter <= '0;
                end
                S_MUL: begin
                    acc  <= acc_next;
                    iter <= iter + 1'b1;
                    if (iter == ITER_LAST) begin
                        bus.product       <= result;
                        bus.product_valid <= 1'b1;
                        bus.prod_count    <= bus.prod_count + 8'd1;
                    end
                end
                S_DONE: begin
                    if (bus.product_ready) bus.product_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_mult_consumer.sv
// Directed bench for fifo_mult_consumer with a cycle-stepped model of the depth-4 operand FIFO.
module tb_fifo_mult_consumer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_mult_consumer_if ifc ();

    fifo_mult_consumer dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    logic [15:0] q[$];
    logic [7:0]  exp_count = 8'd0;

    // One clock: the FIFO pops on an edge where read_req was high and presents the word after it.
    task automatic cyc();
        logic pop;
        pop = ifc.read_req;
        @(posedge clk);
        #1;
        cycle++;
        if (pop === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pop_empty: read_req=1 with left_sig=4, required read_req=0");
                ifc.fifo_read_data = 16'h0000;
            end else begin
                ifc.fifo_read_data = q.pop_front();
            end
        end
        ifc.left_sig = 3'(4 - q.size());
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        ifc.left_sig = 3'(4 - q.size());
    endtask

    task automatic check_idle_outputs(input string nm);
        total++;
        if (ifc.read_req !== 1'b0 || ifc.product_valid !== 1'b0 || ifc.busy !== 1'b0 ||
            ifc.prod_count !== 8'd0 || ifc.product !== 16'h0000) begin
            bad++;
            $display("FAIL %s: read_req=%b valid=%b busy=%b count=%0d product=%h required all zero",
                     nm, ifc.read_req, ifc.product_valid, ifc.busy, ifc.prod_count, ifc.product);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.product_ready = 1'b0;
        ifc.fifo_read_data = 16'h0000;
        ifc.left_sig = 3'd4;
        cyc();
        cyc();
        check_idle_outputs("reset_init");
        rst = 1'b0;
    endtask

    task automatic test_empty();
        for (int i = 0; i < 50; i++) begin
            cyc();
            total++;
            if (ifc.read_req !== 1'b0 || ifc.busy !== 1'b0) begin
                bad++;
                $display("FAIL empty_idle cycle %0d: read_req=%b busy=%b required 0 0",
                         i, ifc.read_req, ifc.busy);
            end
        end
    endtask

    // Single word through an idle block with the sink always ready.
    task automatic run_one(input logic [15:0] w, input logic [15:0] exp, input string nm);
        int t_rd;
        int t_v;
        int pulses;
        t_rd = -1;
        t_v = -1;
        pulses = 0;
        ifc.product_ready = 1'b1;
        push(w);
        for (int i = 0; i < 40 && t_v < 0; i++) begin
            cyc();
            if (ifc.read_req === 1'b1) begin
                pulses++;
                if (t_rd < 0) t_rd = cycle;
            end
            if (ifc.product_valid === 1'b1) t_v = cycle;
        end
        exp_count = exp_count + 8'd1;
        total++;
        if (t_v < 0) begin
            bad++;
            $display("FAIL %s_timeout: no product_valid within 40 cycles, required one", nm);
            return;
        end
        total++;
        if (t_v - t_rd != 10) begin
            bad++;
            $display("FAIL %s_latency: %0d cycles read_req->valid, required 10", nm, t_v - t_rd);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL %s_pulses: read_req high %0d cycles, required 1", nm, pulses);
        end
        total++;
        if (ifc.product !== exp) begin
            bad++;
            $display("FAIL %s_product: got %h required %h", nm, ifc.product, exp);
        end
        total++;
        if (ifc.prod_count !== exp_count) begin
            bad++;
            $display("FAIL %s_count: got %0d required %0d", nm, ifc.prod_count, exp_count);
        end
        cyc();
        total++;
        if (ifc.product_valid !== 1'b0 || ifc.product !== exp) begin
            bad++;
            $display("FAIL %s_after_hs: valid=%b product=%h required 0 %h",
                     nm, ifc.product_valid, ifc.product, exp);
        end
    endtask

    task automatic test_basic();
        run_one(16'h0304, 16'h000C, "basic");
    endtask

    task automatic test_extremes();
`ifdef SIGNED_MULT_EN
        run_one(16'hFFFF, 16'h0001, "s_m1xm1");
        run_one(16'hFD04, 16'hFFF4, "s_m3x4");
        run_one(16'h8080, 16'h4000, "s_m128xm128");
`else
        run_one(16'hFFFF, 16'hFE01, "u_ffxff");
        run_one(16'h00FF, 16'h0000, "u_0xff");
        run_one(16'h8001, 16'h0080, "u_80x01");
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        ifc.product_ready = 1'b1;
        push(16'h0F0F);
        for (int i = 0; i < 10 && seen == 0; i++) begin
            cyc();
            if (ifc.read_req === 1'b1) seen = 1;
        end
        repeat (4) cyc();
        total++;
        if (ifc.busy !== 1'b1 || seen == 0) begin
            bad++;
            $display("FAIL mid_busy: busy=%b read_seen=%0d required 1 1", ifc.busy, seen);
        end
        rst = 1'b1;
        q.delete();
        ifc.left_sig = 3'd4;
        cyc();
        cyc();
        rst = 1'b0;
        check_idle_outputs("reset_mid");
        exp_count = 8'd0;
        repeat (5) cyc();
        total++;
        if (ifc.busy !== 1'b0 || ifc.product_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stays_idle: busy=%b valid=%b required 0 0",
                     ifc.busy, ifc.product_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          t_v;
        int          n;
        logic [15:0] got[2];
        t_v = -1;
        n = 0;
        got[0] = 16'h0000;
        got[1] = 16'h0000;
        ifc.product_ready = 1'b0;
        push(16'h0203);
        push(16'h0505);
        push(16'h0A0B);
        for (int i = 0; i < 40 && t_v < 0; i++) begin
            cyc();
            if (ifc.product_valid === 1'b1) t_v = cycle;
        end
        total++;
        if (t_v < 0 || ifc.product !== 16'h0006) begin
            bad++;
            $display("FAIL bp_first: valid_seen=%0d product=%h required 1 0006", t_v >= 0, ifc.product);
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (ifc.read_req !== 1'b0 || ifc.product_valid !== 1'b1 || ifc.product !== 16'h0006) begin
                bad++;
                $display("FAIL bp_stall cycle %0d: read_req=%b valid=%b product=%h required 0 1 0006",
                         i, ifc.read_req, ifc.product_valid, ifc.product);
            end
        end
        ifc.product_ready = 1'b1;
        cyc();
        for (int i = 0; i < 60 && n < 2; i++) begin
            cyc();
            if (ifc.product_valid === 1'b1) begin
                got[n] = ifc.product;
                n++;
            end
        end
        total++;
        if (n != 2 || got[0] !== 16'h0019 || got[1] !== 16'h006E) begin
            bad++;
            $display("FAIL b2b_order: n=%0d got %h %h required 2 0019 006E", n, got[0], got[1]);
        end
        total++;
        if (ifc.prod_count !== 8'd3) begin
            bad++;
            $display("FAIL b2b_count: got %0d required 3", ifc.prod_count);
        end
    endtask

    task automatic test_count_wrap();
        int pushed;
        int done;
        pushed = 0;
        done = 0;
        rst = 1'b1;
        q.delete();
        ifc.left_sig = 3'd4;
        cyc();
        rst = 1'b0;
        ifc.product_ready = 1'b1;
        for (int g = 0; g < 5000 && done < 256; g++) begin
            if (q.size() < 4 && pushed < 256) begin
                push(16'h0101);
                pushed++;
            end
            cyc();
            if (ifc.product_valid === 1'b1) done++;
        end
        cyc();
        cyc();
        total++;
        if (done != 256) begin
            bad++;
            $display("FAIL wrap_done: got %0d products required 256", done);
        end
        total++;
        if (ifc.prod_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_count: got %0d required 0", ifc.prod_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty();
        test_basic();
        test_extremes();
        test_reset_mid();
        test_back_to_back();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
